// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared widths, BCD limits, controller state encoding and a
//             digit-validity helper for the packed-BCD arithmetic blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int          DIGIT_W = 4;
  localparam int          PAIR_W  = 8;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A nibble above 9 is not a legal BCD digit
  function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_pair_add_cin.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pair_add_cin
//  Purpose  : Combinational two-digit BCD adder with carry in. Each digit is a
//             4-bit carry-lookahead add, a +6 decimal correction and a 4-bit
//             select; the low digit takes the external carry in.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_pair_add_cin
  import bcd_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  // Decimal carry chain: w_c[0] is the pair carry in, w_c[2] the pair carry out
  logic [2:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      logic [3:0] w_ad;
      logic [3:0] w_bd;
      logic [3:0] w_g;
      logic [3:0] w_p;
      logic [4:0] w_cc;
      logic [3:0] w_bin;
      logic [3:0] w_corr;
      logic       w_fix;

      assign w_ad = a[gi*DIGIT_W +: DIGIT_W];
      assign w_bd = b[gi*DIGIT_W +: DIGIT_W];
      assign w_g  = w_ad & w_bd;
      assign w_p  = w_ad ^ w_bd;

      // 4-bit carry lookahead
      assign w_cc[0] = w_c[gi];
      assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
      assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
      assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                     | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
      assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                     | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                     | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);

      assign w_bin = w_p ^ w_cc[3:0];

      // Correction when the binary sum overflowed 4 bits or exceeds 9
      assign w_fix  = w_cc[4] | (w_bin[3] & (w_bin[2] | w_bin[1]));
      assign w_corr = w_bin + 4'd6;

      assign s[gi*DIGIT_W +: DIGIT_W] = w_fix ? w_corr : w_bin;
      assign w_c[gi+1]                = w_fix;
    end
  endgenerate

  assign cout = w_c[2];

endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_serial_add_ctrl
//  Purpose  : Multi-digit packed-BCD adder controller. Accepts two operands,
//             runs them two digits per clock through one shared BCD pair
//             adder (LS pair first) and returns sum, carry out and an
//             invalid-digit flag, all over valid/ready handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W      = 4 * DIGITS;
  localparam int PASSES = DIGITS / 2;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;

  logic [7:0]       w_pair_s;
  logic             w_pair_cout;
  logic             w_bad;
  logic             w_last;
  logic [W-1:0]     w_sum_next;

  bcd_pair_add_cin u_pair (
    .a    (r_a[PAIR_W-1:0]),
    .b    (r_b[PAIR_W-1:0]),
    .cin  (r_carry),
    .s    (w_pair_s),
    .cout (w_pair_cout)
  );

  assign w_bad = is_bad_digit(r_a[3:0]) | is_bad_digit(r_a[7:4])
               | is_bad_digit(r_b[3:0]) | is_bad_digit(r_b[7:4]);

  assign w_last = (r_cnt == CNT_W'(PASSES - 1));

  // New pair enters the sum register from the top so the LS pair ends at bit 0
  generate
    if (DIGITS == 2) begin : g_sum_single
      assign w_sum_next = w_pair_s;
    end else begin : g_sum_shift
      assign w_sum_next = {w_pair_s, sum[W-1:PAIR_W]};
    end
  endgenerate

  // Controller FSM with pass counter, inter-pass carry and operand shifters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum     <= w_sum_next;
          r_carry <= w_pair_cout;
          r_a     <= r_a >> PAIR_W;
          r_b     <= r_b >> PAIR_W;
          err     <= err | w_bad;
          if (w_last) begin
            cout      <= w_pair_cout;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_serial_add_ctrl
//  Purpose  : Scoreboard bench for the serial BCD adder controller, one
//             8-digit and one 2-digit instance sharing clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        err;
    logic        chk_sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv8 = 1'b0, or8 = 1'b1, ir8, ov8, co8, er8;
  logic [31:0] a8 = '0, b8 = '0, s8;
  logic        iv2 = 1'b0, or2 = 1'b1, ir2, ov2, co2, er2;
  logic [7:0]  a2 = '0, b2 = '0, s2;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc8     = 0;
  int   acc2     = 0;
  exp_t q8[$];
  exp_t q2[$];

  bcd_serial_add_ctrl #(.DIGITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .err(er8)
  );

  bcd_serial_add_ctrl #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .err(er2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor for the 8-digit instance: latency, exclusivity and result pops
  logic ov8_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov8_q = 1'b0;
    end else begin
      if (ov8 && !ov8_q) check("lat8", cyc - acc8, 32'd4);
      if (ov8) check("excl8", {31'd0, ir8}, 32'd0);
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          timeout_fail("unexpected_out8");
        end else begin
          e = q8.pop_front();
          if (e.chk_sum) begin
            check("sum8", s8, e.sum);
            check("cout8", {31'd0, co8}, {31'd0, e.cout});
          end
          check("err8", {31'd0, er8}, {31'd0, e.err});
        end
      end
      ov8_q = ov8;
    end
  end

  // Monitor for the 2-digit instance
  logic ov2_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov2_q = 1'b0;
    end else begin
      if (ov2 && !ov2_q) check("lat2", cyc - acc2, 32'd1);
      if (ov2) check("excl2", {31'd0, ir2}, 32'd0);
      if (ov2 && or2) begin
        if (q2.size() == 0) begin
          timeout_fail("unexpected_out2");
        end else begin
          e = q2.pop_front();
          check("sum2", {24'd0, s2}, e.sum);
          check("cout2", {31'd0, co2}, {31'd0, e.cout});
          check("err2", {31'd0, er2}, {31'd0, e.err});
        end
      end
      ov2_q = ov2;
    end
  end

  task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic [31:0] es,
                     input logic ec, input logic ee, input logic chk);
    for (int i = 0; i < 50 && !ir8; i++) begin
      @(posedge clk);
      #1;
    end
    if (!ir8) timeout_fail("ready8");
    a8 = a; b8 = b; iv8 = 1'b1;
    q8.push_back('{sum: es, cout: ec, err: ee, chk_sum: chk});
    @(posedge clk);
    #1;
    acc8 = cyc;
    iv8  = 1'b0;
  endtask

  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es,
                     input logic ec);
    for (int i = 0; i < 50 && !ir2; i++) begin
      @(posedge clk);
      #1;
    end
    if (!ir2) timeout_fail("ready2");
    a2 = a; b2 = b; iv2 = 1'b1;
    q2.push_back('{sum: {24'd0, es}, cout: ec, err: 1'b0, chk_sum: 1'b1});
    @(posedge clk);
    #1;
    acc2 = cyc;
    iv2  = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 50 && q8.size() != 0; i++) @(posedge clk);
    if (q8.size() != 0) timeout_fail("drain8");
    #1;
  endtask

  task automatic drain2();
    for (int i = 0; i < 50 && q2.size() != 0; i++) @(posedge clk);
    if (q2.size() != 0) timeout_fail("drain2");
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, ir8}, 32'd1);
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_sum", s8, 32'd0);
    check("rst_cout", {31'd0, co8}, 32'd0);
    check("rst_err", {31'd0, er8}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic sums, full carry ripple, carry across pairs, invalid digits
    op8(32'h12345678, 32'h87654321, 32'h99999999, 1'b0, 1'b0, 1'b1); drain8();
    op8(32'h99999999, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1); drain8();
    op8(32'h00000099, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b1); drain8();
    op8(32'h50000000, 32'h50000000, 32'h00000000, 1'b1, 1'b0, 1'b1); drain8();
    op8(32'h0000000A, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0); drain8();
    op8(32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1); drain8();

    // Consumer stalls in DONE; in_valid held off meanwhile
    or8 = 1'b0;
    op8(32'h00012345, 32'h00054321, 32'h00066666, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !ov8; i++) begin
      @(posedge clk);
      #1;
    end
    if (!ov8) timeout_fail("done8");
    for (int i = 0; i < 3; i++) begin
      iv8 = 1'b1; a8 = 32'h11111111; b8 = 32'h11111111;
      check("stall_sum", s8, 32'h00066666);
      check("stall_cout", {31'd0, co8}, 32'd0);
      check("stall_err", {31'd0, er8}, 32'd0);
      check("stall_in_ready", {31'd0, ir8}, 32'd0);
      check("stall_out_valid", {31'd0, ov8}, 32'd1);
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", {31'd0, ir8}, 32'd1);
    check("release_out_valid", {31'd0, ov8}, 32'd0);
    check("release_q_empty", q8.size(), 32'd0);
    @(posedge clk);
    #1;
    check("idle_hold_in_ready", {31'd0, ir8}, 32'd1);

    // Reset in the middle of RUN after two passes
    op8(32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, ov8}, 32'd0);
    check("midrst_sum", s8, 32'd0);
    check("midrst_in_ready", {31'd0, ir8}, 32'd1);
    q8.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", {31'd0, ov8}, 32'd0);
    op8(32'h19283746, 32'h08172635, 32'h27456381, 1'b0, 1'b0, 1'b1); drain8();

    // Two-digit instance: single pass per operation
    op2(8'h45, 8'h38, 8'h83, 1'b0); drain2();
    op2(8'h27, 8'h15, 8'h42, 1'b0); drain2();
    op2(8'h12, 8'h34, 8'h46, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst2_out_valid", {31'd0, ov2}, 32'd0);
    check("midrst2_sum", {24'd0, s2}, 32'd0);
    q2.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst2_no_stale", {31'd0, ov2}, 32'd0);
    op2(8'h99, 8'h01, 8'h00, 1'b1); drain2();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
